cache_bus_master: RTL

//  Upstream requester for the generic cache interface (master modport).
//  - Buffers read/write requests from a valid/ready source (trace reader or CPU model) in a small FIFO.
//  - Drives operation/addr/data to the cache, honouring the cache's CAS latency.
//  - Returns read data as a one-cycle response pulse.

---
 rtl/cache_bus_master_pkg.sv | 27 ++
 rtl/cache_req_fifo.sv | 46 ++++
 rtl/cache_bus_master.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/cache_bus_master_pkg.sv
// Shared cache-interface types: bus op encoding, queued request record and CAS latency bound.
package cache_bus_master_pkg;

    localparam int CACHE_ADDR_W    = 32;
    localparam int CACHE_DATA_W    = 8;
    localparam int CAS_LATENCY_MAX = 15;
    localparam int CAS_CNT_W       = $clog2(CAS_LATENCY_MAX + 1);

    // Encoding 2'd3 is unused; such requests are dropped without bus activity.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } inst_t;

    typedef struct packed {
        inst_t                   op;
        logic [CACHE_ADDR_W-1:0] addr;
        logic [CACHE_DATA_W-1:0] data;
    } cache_req_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mst_state_t;

endpackage

// File: rtl/cache_req_fifo.sv
// Request FIFO for the cache master: power-of-2 depth, wrap-bit pointers, head visible combinationally.
module cache_req_fifo
    import cache_bus_master_pkg::*;
#(
    parameter type T     = cache_req_t,
    parameter int  DEPTH = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic push_i,
    input  T     wdata_i,
    input  logic pop_i,
    output T     rdata_o,
    output logic full_o,
    output logic empty_o
);

    localparam int PW = $clog2(DEPTH);

    T           mem [DEPTH];
    logic [PW:0] wr_q, rd_q;
    logic        push_en, pop_en;

    // A full FIFO refuses the push even when the same edge pops.
    assign push_en = push_i && !full_o;
    assign pop_en  = pop_i && !empty_o;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
    assign rdata_o = mem[rd_q[PW-1:0]];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_en) wr_q <= wr_q + 1'b1;
            if (pop_en)  rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push_en) mem[wr_q[PW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/cache_bus_master.sv
// Cache bus master: FIFO-buffered requests issued to the cache with CAS-latency read return.
// Optional issue counters via CACHE_BUS_MASTER_STATS_EN.
//
// state   | meaning
// ST_IDLE | free to issue the FIFO head on the next edge
// ST_WAIT | read outstanding; cnt_q edges left until data is sampled
module cache_bus_master
    import cache_bus_master_pkg::*;
#(
    parameter int ADDR_W      = CACHE_ADDR_W,
    parameter int DATA_W      = CACHE_DATA_W,
    parameter int CAS_LATENCY = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  inst_t             req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output inst_t             bus_op,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_data_out,
    output logic              bus_data_oe,
    input  logic [DATA_W-1:0] bus_data_in,
    output logic              rsp_valid,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DATA_W-1:0] rsp_data
`ifdef CACHE_BUS_MASTER_STATS_EN
    ,
    input  logic              stat_clear,
    output logic [15:0]       stat_reads,
    output logic [15:0]       stat_writes
`endif
);

    cache_req_t           push_req, head;
    logic                 fifo_full, fifo_empty, pop, rsp_done;
    mst_state_t           state_q, state_d;
    logic [CAS_CNT_W-1:0] cnt_q, cnt_d;
    inst_t                bus_op_q, bus_op_d;
    logic [ADDR_W-1:0]    bus_addr_q, bus_addr_d, rsp_addr_q, rsp_addr_d;
    logic [DATA_W-1:0]    bus_dout_q, bus_dout_d, rsp_data_q, rsp_data_d;
    logic                 bus_oe_q, bus_oe_d, rsp_valid_q, rsp_valid_d;

    assign push_req = '{op: req_op, addr: req_addr, data: req_wdata};

    cache_req_fifo #(.T(cache_req_t), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push_i  (req_valid),
        .wdata_i (push_req),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign req_ready = !fifo_full;

    // The edge that samples read data may also issue the next command.
    assign rsp_done = (state_q == ST_WAIT) && (cnt_q == CAS_CNT_W'(1));
    assign pop      = !fifo_empty && ((state_q == ST_IDLE) || rsp_done);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bus_op_q    <= IDLE;
            bus_addr_q  <= '0;
            bus_dout_q  <= '0;
            bus_oe_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_op_q    <= bus_op_d;
            bus_addr_q  <= bus_addr_d;
            bus_dout_q  <= bus_dout_d;
            bus_oe_q    <= bus_oe_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_WAIT) begin
            cnt_d = cnt_q - CAS_CNT_W'(1);
            if (rsp_done) state_d = ST_IDLE;
        end
        if (pop && (head.op == READ)) begin
            state_d = ST_WAIT;
            cnt_d   = CAS_CNT_W'(CAS_LATENCY);
        end
    end

    always_comb begin
        bus_op_d    = IDLE;
        bus_addr_d  = bus_addr_q;
        bus_dout_d  = '0;
        bus_oe_d    = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_addr_d  = rsp_addr_q;
        rsp_data_d  = rsp_data_q;
        if (rsp_done) begin
            rsp_valid_d = 1'b1;
            rsp_addr_d  = bus_addr_q;
            rsp_data_d  = bus_data_in;
        end
        if (pop) begin
            case (head.op)
                READ: begin
                    bus_op_d   = READ;
                    bus_addr_d = head.addr;
                end
                WRITE: begin
                    bus_op_d   = WRITE;
                    bus_addr_d = head.addr;
                    bus_dout_d = head.data;
                    bus_oe_d   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus_op       = bus_op_q;
    assign bus_addr     = bus_addr_q;
    assign bus_data_out = bus_dout_q;
    assign bus_data_oe  = bus_oe_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_addr     = rsp_addr_q;
    assign rsp_data     = rsp_data_q;

`ifdef CACHE_BUS_MASTER_STATS_EN
    logic [15:0] reads_q, writes_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            reads_q  <= '0;
            writes_q <= '0;
        end else if (stat_clear) begin
            reads_q  <= '0;
            writes_q <= '0;
        end else begin
            if (pop && (head.op == READ) && (reads_q != 16'hFFFF))
                reads_q <= reads_q + 16'd1;
            if (pop && (head.op == WRITE) && (writes_q != 16'hFFFF))
                writes_q <= writes_q + 16'd1;
        end
    end

    assign stat_reads  = reads_q;
    assign stat_writes = writes_q;
`endif

endmodule
